// File: rtl/gfx256_pkg.sv
// Shared types for the gfx256 cuvz interpolator front end.
package gfx256_pkg;

    localparam int FRAG_POINT_W = 16;
    localparam int BURST_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE_WAIT = 2'd1,
        DONE       = 2'd2
    } sched_state_t;

    // Default-width fragment; the scheduler re-declares it at its own point_width.
    typedef struct packed {
        logic [FRAG_POINT_W-1:0] x;
        logic [FRAG_POINT_W-1:0] y;
        logic [FRAG_POINT_W-1:0] factor0;
        logic [FRAG_POINT_W-1:0] factor1;
    } frag_t;

endpackage

// File: rtl/gfx256_rr_arb2.sv
// Two-way round-robin winner select with a bounded burst; purely combinational.
module gfx256_rr_arb2 #(
    parameter int CNT_W     = 4,
    parameter int BURST_MAX = 4
) (
    input  logic             req0,
    input  logic             req1,
    input  logic             last_src,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic             grant,
    output logic             winner,
    output logic [CNT_W-1:0] burst_nxt
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic keep;

    assign grant = req0 | req1;
    // A zero count means no burst is running, so the other source goes first.
    assign keep  = (burst_cnt != '0) && (burst_cnt < MAX_CNT);

    always_comb begin
        winner = req1;
        if (req0 && req1)
            winner = keep ? last_src : ~last_src;
        burst_nxt = ONE;
        if (winner == last_src)
            burst_nxt = (burst_cnt < MAX_CNT) ? burst_cnt + ONE : burst_cnt;
    end

endmodule

// File: rtl/gfx256_cuvz_sched.sv
// Shares one gfx256_cuvz interpolator between the triangle (0) and line/bezier (1) rasterizers.
// Define GFX256_CUVZ_SCHED_STATS_EN to add per-source ack counters and a stall counter.
import gfx256_pkg::*;

module gfx256_cuvz_sched #(
    parameter int point_width = FRAG_POINT_W,
    parameter int BURST_MAX   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   hold_i,
    input  logic                   req0_write_i,
    input  logic [point_width-1:0] req0_x_i,
    input  logic [point_width-1:0] req0_y_i,
    input  logic [point_width-1:0] req0_factor0_i,
    input  logic [point_width-1:0] req0_factor1_i,
    input  logic                   req1_write_i,
    input  logic [point_width-1:0] req1_x_i,
    input  logic [point_width-1:0] req1_y_i,
    input  logic [point_width-1:0] req1_factor0_i,
    input  logic [point_width-1:0] req1_factor1_i,
    output logic                   req0_ack_o,
    output logic                   req1_ack_o,
    output logic                   cuvz_write_o,
    output logic [point_width-1:0] cuvz_x_o,
    output logic [point_width-1:0] cuvz_y_o,
    output logic [point_width-1:0] cuvz_factor0_o,
    output logic [point_width-1:0] cuvz_factor1_o,
    input  logic                   cuvz_ack_i,
    output logic                   src_o,
`ifdef GFX256_CUVZ_SCHED_STATS_EN
    input  logic                   stat_clr_i,
    output logic [31:0]            stat0_o,
    output logic [31:0]            stat1_o,
    output logic [31:0]            stall_o,
`endif
    output logic                   busy_o
);

    typedef struct packed {
        logic [point_width-1:0] x;
        logic [point_width-1:0] y;
        logic [point_width-1:0] factor0;
        logic [point_width-1:0] factor1;
    } frag_w_t;

    sched_state_t           state, state_nxt;
    frag_w_t                frag, req0_frag, req1_frag;
    logic                   last_src;
    logic [BURST_CNT_W-1:0] burst_cnt, burst_nxt;
    logic                   arb_grant, arb_winner;
    logic                   do_grant, do_ack;

    assign req0_frag = {req0_x_i, req0_y_i, req0_factor0_i, req0_factor1_i};
    assign req1_frag = {req1_x_i, req1_y_i, req1_factor0_i, req1_factor1_i};

    gfx256_rr_arb2 #(
        .CNT_W     (BURST_CNT_W),
        .BURST_MAX (BURST_MAX)
    ) u_arb (
        .req0      (req0_write_i),
        .req1      (req1_write_i),
        .last_src  (last_src),
        .burst_cnt (burst_cnt),
        .grant     (arb_grant),
        .winner    (arb_winner),
        .burst_nxt (burst_nxt)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // DONE spends one cycle so a requester's write level in its ack cycle is never re-granted.
    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        do_ack    = 1'b0;
        case (state)
            IDLE: if (!hold_i && arb_grant) begin
                do_grant  = 1'b1;
                state_nxt = ISSUE_WAIT;
            end
            ISSUE_WAIT: if (cuvz_ack_i) begin
                do_ack    = 1'b1;
                state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frag         <= '0;
            src_o        <= 1'b0;
            last_src     <= 1'b1;
            burst_cnt    <= '0;
            cuvz_write_o <= 1'b0;
            req0_ack_o   <= 1'b0;
            req1_ack_o   <= 1'b0;
        end else begin
            cuvz_write_o <= do_grant;
            req0_ack_o   <= do_ack & ~src_o;
            req1_ack_o   <= do_ack &  src_o;
            if (do_grant) begin
                frag      <= arb_winner ? req1_frag : req0_frag;
                src_o     <= arb_winner;
                last_src  <= arb_winner;
                burst_cnt <= burst_nxt;
            end
        end
    end

    assign cuvz_x_o       = frag.x;
    assign cuvz_y_o       = frag.y;
    assign cuvz_factor0_o = frag.factor0;
    assign cuvz_factor1_o = frag.factor1;
    assign busy_o         = (state != IDLE);

`ifdef GFX256_CUVZ_SCHED_STATS_EN
    logic stall;

    assign stall = (req0_write_i | req1_write_i) & (busy_o | hold_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat0_o <= '0;
            stat1_o <= '0;
            stall_o <= '0;
        end else if (stat_clr_i) begin
            stat0_o <= '0;
            stat1_o <= '0;
            stall_o <= '0;
        end else begin
            if (do_ack && !src_o) stat0_o <= stat0_o + 32'd1;
            if (do_ack &&  src_o) stat1_o <= stat1_o + 32'd1;
            if (stall)            stall_o <= stall_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gfx256_cuvz_sched.sv
// Self-checking bench for gfx256_cuvz_sched: requester/interpolator models plus a write scoreboard.
`timescale 1ns/1ps
module tb_gfx256_cuvz_sched;

    localparam int PW = 16;

    typedef struct packed {
        logic          src;
        logic [PW-1:0] x;
        logic [PW-1:0] y;
        logic [PW-1:0] f0;
        logic [PW-1:0] f1;
    } exp_t;

    typedef struct {
        logic          src;
        logic [PW-1:0] x, y, f0, f1;
        int            lat;
        int            wlat;
        int            alat;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, hold = 1'b0;
    logic r0w = 1'b0, r1w = 1'b0;
    logic [PW-1:0] r0x = '0, r0y = '0, r0f0 = '0, r0f1 = '0;
    logic [PW-1:0] r1x = '0, r1y = '0, r1f0 = '0, r1f1 = '0;
    logic a0, a1, cw, src, busy, cack;
    logic [PW-1:0] cx, cy, cf0, cf1;
    logic ia_auto = 1'b0, ia_man = 1'b0;
`ifdef GFX256_CUVZ_SCHED_STATS_EN
    logic clr = 1'b0;
    logic [31:0] s0, s1, st;
`endif

    assign cack = ia_auto | ia_man;

    int   checks = 0, failures = 0;
    int   cyc = 0, lat = 3, outst = 0;
    int   last_write_cyc = 0, last_ack_cyc = 0;
    bit   auto_en = 1'b1;
    exp_t q0[$], q1[$], exp_q[$];

    gfx256_cuvz_sched #(.point_width(PW), .BURST_MAX(4)) dut (
        .clk_i(clk), .rst_i(rst), .hold_i(hold),
        .req0_write_i(r0w), .req0_x_i(r0x), .req0_y_i(r0y), .req0_factor0_i(r0f0), .req0_factor1_i(r0f1),
        .req1_write_i(r1w), .req1_x_i(r1x), .req1_y_i(r1y), .req1_factor0_i(r1f0), .req1_factor1_i(r1f1),
        .req0_ack_o(a0), .req1_ack_o(a1),
        .cuvz_write_o(cw), .cuvz_x_o(cx), .cuvz_y_o(cy), .cuvz_factor0_o(cf0), .cuvz_factor1_o(cf1),
        .cuvz_ack_i(cack), .src_o(src),
`ifdef GFX256_CUVZ_SCHED_STATS_EN
        .stat_clr_i(clr), .stat0_o(s0), .stat1_o(s1), .stall_o(st),
`endif
        .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [79:0] act, logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Requesters: hold level and data until the matching ack, then present the next queued fragment.
    initial begin : rq0
        bit got;
        forever begin
            @(negedge clk); got = a0;
            @(posedge clk); #1;
            if (got && q0.size() != 0) void'(q0.pop_front());
            r0w = (q0.size() != 0);
            if (q0.size() != 0) {r0x, r0y, r0f0, r0f1} = {q0[0].x, q0[0].y, q0[0].f0, q0[0].f1};
        end
    end

    initial begin : rq1
        bit got;
        forever begin
            @(negedge clk); got = a1;
            @(posedge clk); #1;
            if (got && q1.size() != 0) void'(q1.pop_front());
            r1w = (q1.size() != 0);
            if (q1.size() != 0) {r1x, r1y, r1f0, r1f1} = {q1[0].x, q1[0].y, q1[0].f0, q1[0].f1};
        end
    end

    // Interpolator: one-cycle completion pulse 'lat' cycles after each write.
    initial begin : interp
        forever begin
            @(negedge clk);
            if (cw) begin
                repeat (lat) @(posedge clk);
                #1 if (auto_en) ia_auto = 1'b1;
                @(posedge clk); #1 ia_auto = 1'b0;
            end
        end
    end

    // Monitor: scoreboard for writes, ack source/timing and one issue per ack.
    initial begin : mon
        bit armed, pw, lsrc;
        exp_t e;
        armed = 1'b0; pw = 1'b0; lsrc = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                armed = 1'b0; pw = 1'b0; outst = 0;
            end else begin
                if (a0 || a1 || armed) begin
                    chk("ack_pulse", 80'({a1, a0}), 80'(armed ? (lsrc ? 2'b10 : 2'b01) : 2'b00));
                    outst = 0;
                    last_ack_cyc = cyc;
                end
                if (cw) begin
                    chk("write_width", 80'(pw), 80'(0));
                    chk("one_issue_per_ack", 80'(outst), 80'(0));
                    chk("busy_at_write", 80'(busy), 80'(1));
                    if (exp_q.size() == 0) chk("unexpected_write", 80'(cw), 80'(0));
                    else begin
                        e = exp_q.pop_front();
                        chk("frag", 80'({src, cx, cy, cf0, cf1}), 80'(e));
                    end
                    outst = 1; lsrc = src; last_write_cyc = cyc;
                end
                pw = cw;
                armed = cack && (outst == 1);
            end
        end
    end

    task automatic wait_idle(string nm);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (n < 400 && !(q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 && outst == 0));
        chk(nm, 80'(n >= 400), 80'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_write(string nm);
        int n = 0;
        do begin @(negedge clk); n++; end while (!cw && n < 50);
        chk(nm, 80'(cw), 80'(1));
    endtask

    // ord[i] is the expected source of grant i; fragments are numbered per source.
    task automatic load(input logic [31:0] ord, input int n);
        int k0 = 0, k1 = 0, k;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            k = ord[i] ? k1 : k0;
            e.src = ord[i];
            e.x   = ord[i] ? 16'h2000 + 16'(k) : 16'h1000 + 16'(k);
            e.y   = ~e.x;
            e.f0  = 16'(k * 16'h0111);
            e.f1  = 16'h8000 ^ 16'(k);
            if (ord[i]) begin q1.push_back(e); k1++; end
            else        begin q0.push_back(e); k0++; end
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        vec_t tv[5];
        exp_t e;
        int   t0;

        tv[0] = '{1'b0, 16'd5,    16'd7,    16'h4000, 16'h4000, 3, 1, 4};
        tv[1] = '{1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 1, 1, 2};
        tv[2] = '{1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 2, 1, 3};
        tv[3] = '{1'b1, 16'h1234, 16'h8765, 16'h2AAA, 16'h5555, 5, 1, 6};
        tv[4] = '{1'b1, 16'h8000, 16'h7FFF, 16'h0001, 16'hC000, 3, 1, 4};

        repeat (3) @(negedge clk);
        chk("reset_state", 80'({cw, cx, cy, cf0, cf1, src, busy, a0, a1}), 80'(0));
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            lat = tv[i].lat;
            e = '{tv[i].src, tv[i].x, tv[i].y, tv[i].f0, tv[i].f1};
            @(negedge clk);
            if (tv[i].src) q1.push_back(e); else q0.push_back(e);
            exp_q.push_back(e);
            t0 = cyc + 1;
            wait_idle("vec_done");
            chk("write_latency", 80'(last_write_cyc - t0), 80'(tv[i].wlat));
            chk("ack_latency", 80'(last_ack_cyc - last_write_cyc), 80'(tv[i].alat));
        end

        // Stale level: identical fragments held back to back, one write per ack.
        lat = 2;
        e = '{1'b0, 16'h0042, 16'h0043, 16'h1000, 16'h2000};
        @(negedge clk);
        repeat (3) begin q0.push_back(e); exp_q.push_back(e); end
        wait_idle("stale_done");
        repeat (5) @(negedge clk);
        chk("stale_idle", 80'({busy, cw}), 80'(0));

        // Contention from reset: 0,0,0,0,1,1,1,1,0 then the leftover source-1 fragment.
        do_reset();
        lat = 1;
        load(32'h0000_02F0, 10);
        wait_idle("contention_done");

        // hold raised while a fragment is in flight.
        lat = 3;
        e = '{1'b0, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
        q0.push_back(e); exp_q.push_back(e);
        wait_write("hold_first_write");
        @(posedge clk); #1 hold = 1'b1;
        e = '{1'b1, 16'h5A5A, 16'hA5A5, 16'h3333, 16'hCCCC};
        q1.push_back(e);
        repeat (12) @(negedge clk);
        chk("hold_first_acked", 80'(q0.size()), 80'(0));
        chk("hold_stalled", 80'({busy, cw}), 80'(0));
        @(posedge clk); #1 hold = 1'b0;
        exp_q.push_back(e);
        @(negedge clk); chk("hold_release_nowrite", 80'(cw), 80'(1'b0));
        @(negedge clk); chk("hold_release_write", 80'(cw), 80'(1'b1));
        wait_idle("hold_done");

        // Interpolator ack while idle is ignored.
        auto_en = 1'b0;
        @(posedge clk); #1 ia_man = 1'b1;
        @(posedge clk); #1 ia_man = 1'b0;
        @(negedge clk); chk("stray_ack", 80'({a0, a1, busy}), 80'(0));
        auto_en = 1'b1;

        // Asynchronous reset in ISSUE_WAIT abandons the fragment.
        lat = 3;
        e = '{1'b1, 16'hBEEF, 16'h0F0F, 16'h1111, 16'h2222};
        q1.push_back(e); exp_q.push_back(e);
        wait_write("rst_write");
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", 80'({cw, cx, cy, cf0, cf1, src, busy, a0, a1}), 80'(0));
        auto_en = 1'b0;
        q0.delete(); q1.delete(); exp_q.delete();
        repeat (6) @(negedge clk);
        auto_en = 1'b1;
        load(32'h0000_0002, 2);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_idle("rst_rerun");

`ifdef GFX256_CUVZ_SCHED_STATS_EN
        do_reset();
        lat = 1;
        load(32'h0000_30F0, 16);
        wait_idle("stats_done");
        chk("stat0", 80'(s0), 80'(10));
        chk("stat1", 80'(s1), 80'(6));
        chk("stall_nonzero", 80'(st != 0), 80'(1));
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk); chk("stat_clear", 80'({s0, s1, st}), 80'(0));
        lat = 3;
        load(32'h0, 1);
        wait_idle("stall_frag_done");
        chk("stall_exact", 80'(st), 80'(5));
        chk("stat0_after_clear", 80'(s0), 80'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
